// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file slice.
//   REG_ZERO / REG_SP / REG_A0 : architectural indices of x0, sp (x2) and a0 (x10).
//   reg_addr_t                 : register index type at the default address width.
//   SP_INIT_DEF                : default reset value of the stack pointer.
package regfile_pkg;

  localparam int          REG_FILE_ADDR_WIDTH_DEF = 5;
  localparam int          DATA_WIDTH_DEF          = 32;
  localparam logic [31:0] SP_INIT_DEF             = 32'h0001_FFFC;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;
  localparam int REG_A0   = 10;

  typedef logic [REG_FILE_ADDR_WIDTH_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight writes.
//   Inputs : clk, rst (async, active high), ad1/ad2 + re1/re2 (consumer
//            operands), we3/ad3 (write-back), rsv_en/rsv_ad (issue reservation).
//   Outputs: stall (RAW hazard on a used operand), rsv_conflict (WAW on
//            reservation), busy_cnt (registered population count of busy bits).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW     = REG_FILE_ADDR_WIDTH_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ad1,
  input  logic [AW-1:0] ad2,
  input  logic          re1,
  input  logic          re2,
  input  logic          we3,
  input  logic [AW-1:0] ad3,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_ad,
  output logic          stall,
  output logic          rsv_conflict,
  output logic [AW:0]   busy_cnt
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = AW + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             set_inc, clr_dec;
  logic             haz1, haz2;

  // NOTE: every signal assigned in a combinational block gets a default on
  // the first lines, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d     = busy_q;
    set_inc    = 1'b0;
    clr_dec    = 1'b0;
    // A reservation wins over a same-edge write to the same index: the new
    // producer supersedes the one completing now.
    if (rsv_en && (rsv_ad != '0)) begin
      busy_d[rsv_ad] = 1'b1;
      set_inc        = !busy_q[rsv_ad];
    end
    if (we3 && (ad3 != '0) && !(rsv_en && (rsv_ad == ad3))) begin
      busy_d[ad3] = 1'b0;
      clr_dec     = busy_q[ad3];
    end
    // Incremental count instead of a full popcount of busy_d.
    busy_cnt_d = busy_cnt_q + CW'(set_inc) - CW'(clr_dec);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // With bypass, a write landing this cycle already supplies the operand.
  always_comb begin
    haz1 = re1 && (ad1 != '0) && busy_q[ad1] && !(BYPASS && we3 && (ad3 == ad1));
    haz2 = re2 && (ad2 != '0) && busy_q[ad2] && !(BYPASS && we3 && (ad3 == ad2));
  end

  assign stall        = haz1 || haz2;
  assign rsv_conflict = rsv_en && (rsv_ad != '0) && busy_q[rsv_ad] && !(we3 && (ad3 == rsv_ad));
  assign busy_cnt     = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, optional
// write-to-read bypass, x0 hardwired to zero, sp preloaded on reset, and a
// busy scoreboard for RAW/WAW detection.
//   Inputs : clk, rst (async, active high), AD1/AD2 + RE1/RE2 (reads),
//            AD3/WE3/WD3 (write), RSV_EN/RSV_AD (reserve destination).
//   Outputs: RD1/RD2 (read data), a0 (x10 tap, never bypassed), stall,
//            rsv_conflict, busy_cnt.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int          REG_FILE_ADDR_WIDTH = REG_FILE_ADDR_WIDTH_DEF,
  parameter int          DATA_WIDTH          = DATA_WIDTH_DEF,
  parameter logic [31:0] SP_INIT             = SP_INIT_DEF,
  parameter bit          BYPASS              = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
  input  logic                           RE1,
  input  logic                           RE2,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
  input  logic                           WE3,
  input  logic [DATA_WIDTH-1:0]          WD3,
  input  logic                           RSV_EN,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] RSV_AD,
  output logic [DATA_WIDTH-1:0]          RD1,
  output logic [DATA_WIDTH-1:0]          RD2,
  output logic [DATA_WIDTH-1:0]          a0,
  output logic                           stall,
  output logic                           rsv_conflict,
  output logic [REG_FILE_ADDR_WIDTH:0]   busy_cnt
);

  localparam int                    AW     = REG_FILE_ADDR_WIDTH;
  localparam int                    DEPTH  = 2 ** AW;
  localparam logic [DATA_WIDTH-1:0] SP_RST = DATA_WIDTH'(SP_INIT);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (WE3 && (AD3 != '0)) regs_d[AD3] = WD3;
  end

  // NOTE: the array is reset on purpose: reset must restore architectural
  // state (zeros plus sp), which rules out an unreset RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (i == REG_SP) ? SP_RST : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [AW-1:0] ad);
    if (ad == AW'(REG_ZERO))             return '0;
    else if (BYPASS && WE3 && (AD3 == ad)) return WD3;
    else                                 return regs_q[ad];
  endfunction

  always_comb begin
    RD1 = read_port(AD1);
    RD2 = read_port(AD2);
  end

  assign a0 = regs_q[AW'(REG_A0)];

  regfile_scoreboard #(
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .ad1          (AD1),
    .ad2          (AD2),
    .re1          (RE1),
    .re2          (RE2),
    .we3          (WE3),
    .ad3          (AD3),
    .rsv_en       (RSV_EN),
    .rsv_ad       (RSV_AD),
    .stall        (stall),
    .rsv_conflict (rsv_conflict),
    .busy_cnt     (busy_cnt)
  );

endmodule
